// File: rtl/pkt_gen.sv
// Sequence/trailer packet source for the MSW/LSW checker: one packet per clock in RUN, 1-cycle start latency.
// No backpressure input; the stream is gated only by start/stop/pause, with optional trailer/sequence error injection.
module pkt_gen #(
  parameter int                   WORD_SIZE = 4,
  parameter logic [WORD_SIZE-1:0] TRAILER   = WORD_SIZE'(4'hF),
  parameter int                   BURST_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic                 inj_f,
  input  logic                 inj_seq,
  output logic [WORD_SIZE-1:0] MSW,
  output logic [WORD_SIZE-1:0] LSW,
  output logic                 pkt_valid,
  output logic                 busy,
  output logic [1:0]           gen_state,
  output logic [15:0]          pkt_count,
  output logic [7:0]           inj_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_seq;
  logic [BURST_W-1:0]   r_len;
  logic [BURST_W-1:0]   r_sent;
  logic                 r_pend_f;
  logic                 r_pend_seq;

  logic                 w_active;
  logic                 w_burst_done;
  logic                 w_to_idle;
  logic                 w_want_f;
  logic                 w_want_seq;
  logic                 w_serve_seq;
  logic [WORD_SIZE-1:0] w_pkt_msw;
  logic [WORD_SIZE-1:0] w_pkt_lsw;
  logic [WORD_SIZE-1:0] w_seq_next;
  logic [15:0]          w_pkt_count_inc;
  logic [7:0]           w_inj_count_inc;

  assign w_active     = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign w_burst_done = (r_state == ST_RUN) && (r_len != '0) && (r_sent == r_len);
  assign w_to_idle    = stop || w_burst_done ||
                        ((r_state == ST_IDLE) ? !start : !w_active);

  // A request is served by the packet emitted at the same edge; a pulse that
  // coincides with serving an already-pending request re-arms it.
  assign w_want_f    = r_pend_f | inj_f;
  assign w_want_seq  = r_pend_seq | inj_seq;
  assign w_serve_seq = w_want_seq & ~w_want_f;

  assign w_pkt_msw  = w_serve_seq ? r_seq + WORD_SIZE'(1) : r_seq;
  assign w_pkt_lsw  = w_want_f ? ~TRAILER : TRAILER;
  assign w_seq_next = r_seq + (w_serve_seq ? WORD_SIZE'(2) : WORD_SIZE'(1));

  assign w_pkt_count_inc = (pkt_count == 16'hFFFF) ? pkt_count : pkt_count + 16'd1;
  assign w_inj_count_inc = (inj_count == 8'hFF)    ? inj_count : inj_count + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_seq      <= '0;
      r_len      <= '0;
      r_sent     <= '0;
      r_pend_f   <= 1'b0;
      r_pend_seq <= 1'b0;
      MSW        <= '0;
      LSW        <= '0;
      pkt_valid  <= 1'b0;
      busy       <= 1'b0;
      gen_state  <= ST_IDLE;
      pkt_count  <= '0;
      inj_count  <= '0;
    end else if (w_to_idle) begin
      r_state    <= ST_IDLE;
      gen_state  <= ST_IDLE;
      busy       <= 1'b0;
      pkt_valid  <= 1'b0;
      MSW        <= '0;
      LSW        <= '0;
      r_pend_f   <= 1'b0;
      r_pend_seq <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      // Burst start: packet 0 goes out on this edge, requests are not honoured yet.
      r_state    <= ST_RUN;
      gen_state  <= ST_RUN;
      busy       <= 1'b1;
      pkt_valid  <= 1'b1;
      r_len      <= burst_len;
      r_seq      <= WORD_SIZE'(1);
      r_sent     <= BURST_W'(1);
      MSW        <= '0;
      LSW        <= TRAILER;
      r_pend_f   <= 1'b0;
      r_pend_seq <= 1'b0;
      pkt_count  <= w_pkt_count_inc;
    end else if (pause) begin
      r_state    <= ST_PAUSE;
      gen_state  <= ST_PAUSE;
      busy       <= 1'b1;
      pkt_valid  <= 1'b0;
      r_pend_f   <= w_want_f;
      r_pend_seq <= w_want_seq;
    end else begin
      r_state    <= ST_RUN;
      gen_state  <= ST_RUN;
      busy       <= 1'b1;
      pkt_valid  <= 1'b1;
      MSW        <= w_pkt_msw;
      LSW        <= w_pkt_lsw;
      r_seq      <= w_seq_next;
      r_sent     <= r_sent + BURST_W'(1);
      pkt_count  <= w_pkt_count_inc;
      if (w_want_f || w_want_seq) begin
        inj_count <= w_inj_count_inc;
      end
      r_pend_f   <= r_pend_f & inj_f;
      r_pend_seq <= w_serve_seq ? (r_pend_seq & inj_seq) : w_want_seq;
    end
  end

endmodule

// File: tb/tb_pkt_gen.sv
// Bench for pkt_gen: vector table, directed corner sequences and random traffic checked against a packet-level model.
module tb_pkt_gen;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, inj_f, inj_seq;
  logic [7:0] burst_len;
  logic [3:0] MSW, LSW;
  logic       pkt_valid, busy;
  logic [1:0] gen_state;
  logic [15:0] pkt_count;
  logic [7:0]  inj_count;

  pkt_gen #(.WORD_SIZE(4), .TRAILER(4'hF), .BURST_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .burst_len(burst_len), .inj_f(inj_f), .inj_seq(inj_seq),
    .MSW(MSW), .LSW(LSW), .pkt_valid(pkt_valid), .busy(busy),
    .gen_state(gen_state), .pkt_count(pkt_count), .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Packet-level model: mode 0 idle, 1 run, 2 pause
  int m_mode, m_seq, m_sent, m_len;
  bit m_pf, m_ps;
  int e_msw, e_lsw, e_vld, e_pkt, e_inj;
  localparam int TR = 15;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_idle();
    m_mode = 0; m_pf = 0; m_ps = 0;
    e_msw = 0; e_lsw = 0; e_vld = 0;
  endtask

  task automatic model_step();
    bit want_f, want_s;
    if (reset) begin
      model_idle();
      m_seq = 0; m_sent = 0; m_len = 0; e_pkt = 0; e_inj = 0;
    end else if (m_mode == 0) begin
      model_idle();
      if (start && !stop) begin
        m_len = burst_len; m_seq = 1; m_sent = 1; m_mode = 1;
        e_msw = 0; e_lsw = TR; e_vld = 1;
        if (e_pkt < 65535) e_pkt++;
      end
    end else if (stop || (m_mode == 1 && m_len != 0 && m_sent >= m_len)) begin
      model_idle();
    end else if (pause) begin
      m_mode = 2; e_vld = 0;
      m_pf = m_pf || inj_f; m_ps = m_ps || inj_seq;
    end else begin
      want_f = m_pf || inj_f;
      want_s = m_ps || inj_seq;
      if (want_f) begin
        e_msw = m_seq; e_lsw = TR ^ 15; m_seq = (m_seq + 1) % 16;
        m_pf = m_pf && inj_f; m_ps = want_s;
      end else if (want_s) begin
        e_msw = (m_seq + 1) % 16; e_lsw = TR; m_seq = (m_seq + 2) % 16;
        m_ps = m_ps && inj_seq; m_pf = 0;
      end else begin
        e_msw = m_seq; e_lsw = TR; m_seq = (m_seq + 1) % 16;
      end
      if ((want_f || want_s) && e_inj < 255) e_inj++;
      if (e_pkt < 65535) e_pkt++;
      m_sent++; e_vld = 1; m_mode = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("msw", MSW, e_msw);
    chk("lsw", LSW, e_lsw);
    chk("valid", pkt_valid, e_vld);
    chk("busy", busy, (m_mode != 0) ? 1 : 0);
    chk("state", gen_state, m_mode);
    chk("pkt_count", pkt_count, e_pkt);
    chk("inj_count", inj_count, e_inj);
  endtask

  task automatic drive(input logic st, input logic sp, input logic ps,
                       input logic [7:0] len, input logic f, input logic s);
    start = st; stop = sp; pause = ps; burst_len = len; inj_f = f; inj_seq = s;
  endtask

  typedef struct {
    logic       st, sp;
    logic [7:0] len;
    logic [3:0] e_msw, e_lsw;
    logic       e_vld;
    logic [1:0] e_st;
  } vec_t;
  vec_t tbl[8];

  initial begin
    model_idle();
    m_seq = 0; m_sent = 0; m_len = 0; e_pkt = 0; e_inj = 0;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1);
    tick();
    tick();
    chk("reset_valid", pkt_valid, 0);
    chk("reset_state", gen_state, 0);
    chk("reset_pkt_count", pkt_count, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();

    // Burst of 5; burst_len changes mid-burst must be ignored (latched at start)
    tbl[0] = '{1'b1, 1'b1, 8'd5, 4'h0, 4'h0, 1'b0, 2'b00};
    tbl[1] = '{1'b1, 1'b0, 8'd5, 4'h0, 4'hF, 1'b1, 2'b01};
    tbl[2] = '{1'b0, 1'b0, 8'd1, 4'h1, 4'hF, 1'b1, 2'b01};
    tbl[3] = '{1'b1, 1'b0, 8'd1, 4'h2, 4'hF, 1'b1, 2'b01};
    tbl[4] = '{1'b0, 1'b0, 8'd1, 4'h3, 4'hF, 1'b1, 2'b01};
    tbl[5] = '{1'b0, 1'b0, 8'd1, 4'h4, 4'hF, 1'b1, 2'b01};
    tbl[6] = '{1'b0, 1'b0, 8'd1, 4'h0, 4'h0, 1'b0, 2'b00};
    tbl[7] = '{1'b0, 1'b0, 8'd1, 4'h0, 4'h0, 1'b0, 2'b00};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].st, tbl[i].sp, 1'b0, tbl[i].len, 1'b0, 1'b0);
      tick();
      chk("tbl_msw", MSW, tbl[i].e_msw);
      chk("tbl_lsw", LSW, tbl[i].e_lsw);
      chk("tbl_valid", pkt_valid, tbl[i].e_vld);
      chk("tbl_state", gen_state, tbl[i].e_st);
    end
    chk("burst5_pkt_count", pkt_count, 5);

    // Continuous run: wrap E,F,0,1 then stop
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (i >= 14 && i <= 17) begin
        chk("wrap_msw", MSW, i % 16);
        chk("wrap_lsw", LSW, 15);
      end
    end
    stop = 1'b1;
    tick();
    chk("stop_valid", pkt_valid, 0);
    stop = 1'b0;
    tick();

    // Trailer injection on the 3rd packet
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    inj_f = 1'b1;
    tick();
    chk("injf_msw", MSW, 2);
    chk("injf_lsw", LSW, 0);
    inj_f = 1'b0;
    tick();
    chk("injf_after_msw", MSW, 3);
    chk("injf_after_lsw", LSW, 15);
    chk("injf_count", inj_count, 1);

    // Sequence skip at MSW=6, then both requests together
    tick(); tick(); tick();
    chk("pre_seq_msw", MSW, 6);
    inj_seq = 1'b1;
    tick();
    chk("injseq_msw", MSW, 8);
    inj_seq = 1'b0;
    tick();
    chk("injseq_next_msw", MSW, 9);
    inj_f = 1'b1; inj_seq = 1'b1;
    tick();
    chk("both_first_msw", MSW, 10);
    chk("both_first_lsw", LSW, 0);
    inj_f = 1'b0; inj_seq = 1'b0;
    tick();
    chk("both_second_msw", MSW, 12);
    chk("both_second_lsw", LSW, 15);
    chk("both_inj_count", inj_count, 4);

    // Pause 3 cycles at MSW=4
    stop = 1'b1;
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_valid", pkt_valid, 0);
      chk("pause_msw", MSW, 4);
      chk("pause_state", gen_state, 2);
    end
    pause = 1'b0;
    tick();
    chk("resume_msw", MSW, 5);
    chk("resume_valid", pkt_valid, 1);

    // Reset mid-burst with a trailer request pending
    pause = 1'b1;
    tick();
    inj_f = 1'b1;
    tick();
    reset = 1'b1; start = 1'b1; pause = 1'b0;
    tick();
    chk("rst_valid", pkt_valid, 0);
    chk("rst_msw", MSW, 0);
    chk("rst_lsw", LSW, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inj_count", inj_count, 0);
    reset = 1'b0; inj_f = 1'b0; burst_len = 8'd3;
    tick();
    start = 1'b0;
    tick();
    chk("restart_msw", MSW, 1);
    chk("restart_lsw", LSW, 15);
    chk("restart_inj_count", inj_count, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      pause     = ($urandom_range(0, 7) == 0);
      burst_len = 8'($urandom_range(0, 6));
      inj_f     = ($urandom_range(0, 9) == 0);
      inj_seq   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
